// File: rtl/serial_rx8.sv
// LSB-first serial-to-byte receiver with a sync-marked frame start and a 2-entry output FIFO.
// Optional even-parity bit per frame when SERIAL_RX8_PARITY_EN is defined (adds PAR state and par_err).
module serial_rx8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sdata,
  input  logic       sen,
  input  logic       sync,
  input  logic       byte_ready,
  input  logic       ovr_clr,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       overrun,
  output logic       frame_err,
`ifdef SERIAL_RX8_PARITY_EN
  output logic       par_err,
`endif
  output logic       busy
);

`ifdef SERIAL_RX8_PARITY_EN
  typedef enum logic [1:0] {IDLE, DATA, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, DATA} state_t;
`endif

  state_t     r_state;
  logic [2:0] r_cnt;
  logic [7:0] r_shift;
  logic       r_frame_err;
`ifdef SERIAL_RX8_PARITY_EN
  logic       r_par_err;
  logic       w_par_ok;
`endif

  logic [7:0] r_e0, r_e1;
  logic [1:0] r_occ;
  logic       r_overrun;

  logic       w_push;
  logic [7:0] w_push_byte;
  logic       w_pop;
  logic       w_full;
  logic       w_resync;

  // A sync strobe outside IDLE abandons the frame in progress.
  assign w_resync = sen && sync && (r_state != IDLE);

`ifdef SERIAL_RX8_PARITY_EN
  assign w_par_ok    = ~(^r_shift ^ sdata);
  assign w_push      = (r_state == PAR) && sen && !sync && w_par_ok;
  assign w_push_byte = r_shift;
`else
  assign w_push      = (r_state == DATA) && sen && !sync && (r_cnt == 3'd7);
  assign w_push_byte = {sdata, r_shift[6:0]};
`endif

  assign byte_valid = (r_occ != 2'd0);
  assign w_full     = (r_occ == 2'd2);
  assign w_pop      = byte_valid && byte_ready;
  assign byte_out   = byte_valid ? r_e0 : 8'h00;
  assign overrun    = r_overrun;
  assign frame_err  = r_frame_err;
  assign busy       = (r_state != IDLE);
`ifdef SERIAL_RX8_PARITY_EN
  assign par_err    = r_par_err;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= 3'd0;
      r_shift     <= 8'h00;
      r_frame_err <= 1'b0;
`ifdef SERIAL_RX8_PARITY_EN
      r_par_err   <= 1'b0;
`endif
    end else begin
      r_frame_err <= 1'b0;
`ifdef SERIAL_RX8_PARITY_EN
      r_par_err   <= 1'b0;
`endif
      if (sen) begin
        if ((r_state == IDLE && sync) || w_resync) begin
          r_shift     <= {7'h00, sdata};
          r_cnt       <= 3'd1;
          r_state     <= DATA;
          r_frame_err <= w_resync;
        end else begin
          case (r_state)
            DATA: begin
              r_shift[r_cnt] <= sdata;
              r_cnt          <= r_cnt + 3'd1;
              if (r_cnt == 3'd7) begin
`ifdef SERIAL_RX8_PARITY_EN
                r_state <= PAR;
`else
                r_state <= IDLE;
`endif
              end
            end
`ifdef SERIAL_RX8_PARITY_EN
            PAR: begin
              r_state   <= IDLE;
              r_par_err <= ~w_par_ok;
            end
`endif
            default: r_state <= IDLE;
          endcase
        end
      end
    end
  end

  // Head is always r_e0; a pop shifts r_e1 forward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e0  <= 8'h00;
      r_e1  <= 8'h00;
      r_occ <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b11: begin
          if (r_occ == 2'd1) begin
            r_e0 <= w_push_byte;
          end else begin
            r_e0 <= r_e1;
            r_e1 <= w_push_byte;
          end
        end
        2'b10: begin
          if (r_occ == 2'd0) begin
            r_e0  <= w_push_byte;
            r_occ <= 2'd1;
          end else if (r_occ == 2'd1) begin
            r_e1  <= w_push_byte;
            r_occ <= 2'd2;
          end
        end
        2'b01: begin
          r_e0  <= r_e1;
          r_occ <= r_occ - 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_overrun <= 1'b0;
    else if (w_push && w_full && !w_pop)
      r_overrun <= 1'b1;
    else if (ovr_clr)
      r_overrun <= 1'b0;
  end

endmodule

// File: doc/serial_rx8.md
SERIAL_RX8 -- requirements
Module: serial_rx8

Interface
REQ-001 The module SHALL expose these ports: clk  in  1  single clock, all state updates on rising edge.
REQ-002 rst_n  in  1  asynchronous active-low reset.
REQ-003 sdata  in  1  serial data bit, LSB first, sampled only when sen=1.
REQ-004 sen  in  1  bit-valid strobe, one bit accepted per cycle with sen=1.
REQ-005 sync  in  1  frame-start marker, qualified by sen, marks the current sdata as bit 0.
REQ-006 byte_ready  in  1  consumer ready.
REQ-007 ovr_clr  in  1  clears sticky overrun.
REQ-008 byte_out  out  8  head-of-buffer byte.
REQ-009 byte_valid  out  1  buffer non-empty.
REQ-010 overrun  out  1  sticky, a completed byte was dropped.
REQ-011 frame_err  out  1  one-cycle pulse on resync mid-frame.
REQ-012 busy  out  1  FSM not in IDLE.

Function
REQ-013 FSM states SHALL be IDLE, DATA and PAR; PAR exists only with the configuration macro defined.
REQ-014 IDLE: sen=1 and sync=1 -> store sdata as bit 0, bit count=1, go to DATA; sen=1 with sync=0 -> bit ignored.
REQ-015 DATA: each sen=1 stores sdata at bit[count] and increments the 3-bit count; after bit 7 is stored the frame is complete.
REQ-016 On frame completion without PARITY_EN the byte SHALL be pushed and the FSM SHALL return to IDLE in the same edge.
REQ-017 In DATA, sen=1 with sync=1 SHALL discard the partial byte, store sdata as new bit 0, set count=1, stay in DATA and pulse frame_err for one cycle.
REQ-018 The output buffer SHALL be a 2-entry FIFO; byte_valid=1 iff occupancy>0; byte_out shows the oldest entry, and is 8'h00 when empty.
REQ-019 A pop SHALL occur on any edge with byte_valid=1 and byte_ready=1.
REQ-020 Latency: a bit-7 strobe (or parity strobe) at edge N into an empty FIFO SHALL give byte_valid=1 after edge N.
REQ-021 A push with the FIFO full and no simultaneous pop SHALL drop the new byte, keep the FIFO contents, and set overrun.
REQ-022 A push and a pop on the same edge with the FIFO full SHALL both succeed with no overrun.
REQ-023 A push and a pop on the same edge with exactly 1 entry SHALL leave 1 entry, the new byte.
REQ-024 overrun SHALL clear on ovr_clr=1; if a set and ovr_clr=1 occur on the same edge, set wins.
REQ-025 sen=0 SHALL hold FSM, count and partial byte indefinitely.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, count=0, FIFO empty, byte_out=8'h00, byte_valid=0, overrun=0, frame_err=0, busy=0, and par_err=0 where present.
REQ-027 Reset mid-frame SHALL discard the partial byte.
REQ-028 The first frame after reset release SHALL require a new sync.

Configuration
REQ-029 With SERIAL_RX8_PARITY_EN defined, frame completion SHALL go to PAR.
REQ-030 In PAR, on the next sen=1 the receiver SHALL check even parity, meaning XOR of the 8 data bits and sdata equals 0.
REQ-031 On a PAR check, pass -> push and go to IDLE; fail -> discard, pulse output par_err (out, 1) for one cycle, and go to IDLE.
REQ-032 In PAR, sync=1 with sen=1 SHALL act as in REQ-017, including a frame_err pulse.
REQ-033 Without SERIAL_RX8_PARITY_EN, there SHALL be no PAR state and no par_err port, and bytes SHALL be 8 bits with no parity.

Verification
REQ-034 Bytes: sync with bits LSB-first of 8'hA5 on 8 consecutive sen strobes -> byte_out=8'hA5 and byte_valid=1 the cycle after the 8th strobe; byte_ready=1 -> empty next cycle.
REQ-035 Gapped: 8'h3C sent with sen=0 gaps of 1-3 cycles between bits -> 8'h3C received, busy=1 throughout the frame.
REQ-036 Overrun: byte_ready=0, send 8'h01, 8'h02, 8'h03 -> FIFO holds 8'h01 then 8'h02, overrun=1; ovr_clr -> overrun=0.
REQ-037 Resync: sync reasserted after 4 bits, then 8'h5A sent -> frame_err pulse, only 8'h5A received.
REQ-038 Reset: rst_n pulse low after 5 bits of a frame, then full 8'hFF frame -> only 8'hFF received, all outputs 0 during reset.
REQ-039 PARITY_EN: 8'h07 sent with parity bit 1 -> accepted; with parity bit 0 -> par_err pulse and no byte_valid.
